// File: rtl/ccu_ctrl_pkg.sv
// Shared types for the cache-side ACE snoop responder: update ops, CR bit map,
// snoop encodings, AC/CR/CD channel structs and the snoop decision function.
package ccu_ctrl_pkg;

    localparam int unsigned AceAddrWidth = 64;
    localparam int unsigned AceDataWidth = 64;
    localparam int unsigned CrRespWidth  = 5;

    typedef enum logic [1:0] {
        UPD_NONE       = 2'd0,
        UPD_CLEAN      = 2'd1,
        UPD_DOWNGRADE  = 2'd2,
        UPD_INVALIDATE = 2'd3
    } cache_update_e;

    localparam int unsigned CrDataTransfer = 0;
    localparam int unsigned CrError        = 1;
    localparam int unsigned CrPassDirty    = 2;
    localparam int unsigned CrIsShared     = 3;
    localparam int unsigned CrWasUnique    = 4;

    localparam logic [3:0] SNP_READ_ONCE      = 4'b0000;
    localparam logic [3:0] SNP_READ_SHARED    = 4'b0001;
    localparam logic [3:0] SNP_READ_CLEAN     = 4'b0010;
    localparam logic [3:0] SNP_READ_NSD       = 4'b0011;
    localparam logic [3:0] SNP_READ_UNIQUE    = 4'b0111;
    localparam logic [3:0] SNP_CLEAN_SHARED   = 4'b1000;
    localparam logic [3:0] SNP_CLEAN_INVALID  = 4'b1001;
    localparam logic [3:0] SNP_MAKE_INVALID   = 4'b1101;

    typedef struct packed {
        logic [AceAddrWidth-1:0] addr;
        logic [3:0]              snoop;
    } ace_ac_t;

    typedef struct packed {
        logic [AceDataWidth-1:0] data;
        logic                    last;
    } ace_cd_t;

    typedef struct packed {
        logic    ac_valid;
        ace_ac_t ac;
        logic    cr_ready;
        logic    cd_ready;
    } ace_snoop_req_t;

    typedef struct packed {
        logic                   ac_ready;
        logic                   cr_valid;
        logic [CrRespWidth-1:0] cr_resp;
        logic                   cd_valid;
        ace_cd_t                cd;
    } ace_snoop_resp_t;

    typedef struct packed {
        logic [CrRespWidth-1:0] cr_resp;
        cache_update_e          upd_op;
    } snoop_decision_t;

    // Misses and unrecognised encodings answer with an all-zero CR and leave the line alone.
    function automatic snoop_decision_t snoop_decide(input logic [3:0] snoop,
                                                     input logic       hit,
                                                     input logic       dirty,
                                                     input logic       shared);
        snoop_decision_t d;
        logic            dt;
        logic            pd;
        logic            is_sh;
        logic            known;
        d.cr_resp = '0;
        d.upd_op  = UPD_NONE;
        dt        = 1'b0;
        pd        = 1'b0;
        is_sh     = 1'b0;
        known     = 1'b1;
        case (snoop)
            SNP_READ_ONCE: begin
                dt    = 1'b1;
                is_sh = 1'b1;
            end
            SNP_READ_SHARED, SNP_READ_CLEAN, SNP_READ_NSD: begin
                dt       = 1'b1;
                pd       = dirty;
                is_sh    = 1'b1;
                d.upd_op = UPD_DOWNGRADE;
            end
            SNP_READ_UNIQUE: begin
                dt       = 1'b1;
                pd       = dirty;
                d.upd_op = UPD_INVALIDATE;
            end
            SNP_CLEAN_INVALID: begin
                dt       = dirty;
                pd       = dirty;
                d.upd_op = UPD_INVALIDATE;
            end
            SNP_CLEAN_SHARED: begin
                dt       = dirty;
                pd       = dirty;
                is_sh    = 1'b1;
                d.upd_op = dirty ? UPD_CLEAN : UPD_NONE;
            end
            SNP_MAKE_INVALID: begin
                d.upd_op = UPD_INVALIDATE;
            end
            default: known = 1'b0;
        endcase
        if (hit && known) begin
            d.cr_resp[CrDataTransfer] = dt;
            d.cr_resp[CrError]        = 1'b0;
            d.cr_resp[CrPassDirty]    = pd;
            d.cr_resp[CrIsShared]     = is_sh;
            d.cr_resp[CrWasUnique]    = ~shared;
        end else begin
            d.cr_resp = '0;
            d.upd_op  = UPD_NONE;
        end
        return d;
    endfunction

endpackage

// File: rtl/ccu_snoop_responder.sv
// ACE snoop responder: one AC snoop at a time, dcache lookup, optional state
// update, then CR response and (when DataTransfer) the buffered line as CD beats.
module ccu_snoop_responder
    import ccu_ctrl_pkg::*;
#(
    parameter int unsigned DcacheLineWidth = 128,
    parameter int unsigned AxiDataWidth    = 64,
    parameter int unsigned AddrWidth       = 64,
    parameter type         snoop_req_t     = ace_snoop_req_t,
    parameter type         snoop_resp_t    = ace_snoop_resp_t
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  snoop_req_t                 snoop_req_i,
    output snoop_resp_t                snoop_resp_o,
    output logic                       lookup_req_o,
    output logic [AddrWidth-1:0]       lookup_addr_o,
    input  logic                       lookup_gnt_i,
    input  logic                       lookup_valid_i,
    input  logic                       lookup_hit_i,
    input  logic                       lookup_dirty_i,
    input  logic                       lookup_shared_i,
    input  logic [DcacheLineWidth-1:0] lookup_data_i,
    output logic                       update_req_o,
    output logic [1:0]                 update_op_o,
    input  logic                       update_gnt_i
);

    localparam int unsigned DcacheLineWords = DcacheLineWidth / AxiDataWidth;
    localparam int unsigned BeatWidth       = $clog2(DcacheLineWords);
    localparam int unsigned LineOffWidth    = $clog2(DcacheLineWidth / 8);
    localparam logic [BeatWidth-1:0] LastBeat = BeatWidth'(DcacheLineWords - 1);
    localparam logic [AddrWidth-1:0] LineMask = (AddrWidth'(1) << LineOffWidth) - AddrWidth'(1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOOKUP    = 3'd1;
    localparam logic [2:0] ST_WAIT_DATA = 3'd2;
    localparam logic [2:0] ST_UPDATE    = 3'd3;
    localparam logic [2:0] ST_SEND_CR   = 3'd4;
    localparam logic [2:0] ST_SEND_CD   = 3'd5;

    logic [2:0]                 state_reg;
    logic [2:0]                 state_next;
    logic [BeatWidth-1:0]       beat_reg;
    logic [BeatWidth-1:0]       beat_next;
    logic [3:0]                 snoop_reg;
    logic [AddrWidth-1:0]       addr_reg;
    logic [CrRespWidth-1:0]     cr_resp_reg;
    cache_update_e              upd_op_reg;
    logic [DcacheLineWidth-1:0] line_reg;

    logic                       ac_ready;
    logic                       ac_hs;
    logic                       capture;
    logic                       cd_last;
    snoop_decision_t            decision;
    logic [AxiDataWidth-1:0]    line_words [DcacheLineWords];

    for (genvar gi = 0; gi < DcacheLineWords; gi++) begin : g_line_words
        assign line_words[gi] = line_reg[gi*AxiDataWidth +: AxiDataWidth];
    end

    // Gated by rst_ni so no snoop can be accepted while the block is held in reset.
    assign ac_ready = (state_reg == ST_IDLE) && rst_ni;
    assign ac_hs    = snoop_req_i.ac_valid && ac_ready;
    assign capture  = (state_reg == ST_WAIT_DATA) && lookup_valid_i;
    assign cd_last  = (beat_reg == LastBeat);

    always_comb begin
        decision = snoop_decide(snoop_reg, lookup_hit_i, lookup_dirty_i, lookup_shared_i);
    end

    always_comb begin
        state_next = state_reg;
        beat_next  = beat_reg;
        case (state_reg)
            ST_IDLE: begin
                if (ac_hs) begin
                    state_next = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (lookup_gnt_i) begin
                    state_next = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if (lookup_valid_i) begin
                    state_next = (decision.upd_op != UPD_NONE) ? ST_UPDATE : ST_SEND_CR;
                end
            end
            ST_UPDATE: begin
                if (update_gnt_i) begin
                    state_next = ST_SEND_CR;
                end
            end
            ST_SEND_CR: begin
                if (snoop_req_i.cr_ready) begin
                    if (cr_resp_reg[CrDataTransfer]) begin
                        state_next = ST_SEND_CD;
                        beat_next  = '0;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_SEND_CD: begin
                if (snoop_req_i.cd_ready) begin
                    beat_next = cd_last ? '0 : beat_reg + 1'b1;
                    if (cd_last) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Line is buffered at lookup time, so a later invalidate cannot disturb the CD beats.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg   <= ST_IDLE;
            beat_reg    <= '0;
            snoop_reg   <= '0;
            addr_reg    <= '0;
            cr_resp_reg <= '0;
            upd_op_reg  <= UPD_NONE;
            line_reg    <= '0;
        end else begin
            state_reg <= state_next;
            beat_reg  <= beat_next;
            if (ac_hs) begin
                snoop_reg <= snoop_req_i.ac.snoop;
                addr_reg  <= snoop_req_i.ac.addr[AddrWidth-1:0];
            end
            if (capture) begin
                cr_resp_reg <= decision.cr_resp;
                upd_op_reg  <= decision.upd_op;
                line_reg    <= lookup_data_i;
            end
        end
    end

    assign lookup_req_o  = (state_reg == ST_LOOKUP);
    assign lookup_addr_o = addr_reg & ~LineMask;
    assign update_req_o  = (state_reg == ST_UPDATE);
    assign update_op_o   = upd_op_reg;

    always_comb begin
        snoop_resp_o          = '0;
        snoop_resp_o.ac_ready = ac_ready;
        snoop_resp_o.cr_valid = (state_reg == ST_SEND_CR);
        snoop_resp_o.cr_resp  = cr_resp_reg;
        snoop_resp_o.cd_valid = (state_reg == ST_SEND_CD);
        snoop_resp_o.cd.data  = line_words[beat_reg];
        snoop_resp_o.cd.last  = cd_last;
    end

endmodule

// File: tb/tb_ccu_snoop_responder.sv
// Bench for ccu_snoop_responder: directed ACE snoop cases plus randomized snoops with
// stalls, checked by a queue scoreboard against a table-level reference model.
module tb_ccu_snoop_responder;
    import ccu_ctrl_pkg::*;

    localparam int LineW = 128;
    localparam int DataW = 64;
    localparam int Words = LineW / DataW;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    logic        ac_valid = 1'b0;
    logic [3:0]  ac_snoop = '0;
    logic [63:0] ac_addr  = '0;
    logic        cr_ready = 1'b0;
    logic        cd_ready = 1'b0;

    ace_snoop_req_t  snoop_req;
    ace_snoop_resp_t snoop_resp;
    assign snoop_req = '{ac_valid: ac_valid, ac: '{addr: ac_addr, snoop: ac_snoop},
                         cr_ready: cr_ready, cd_ready: cd_ready};

    logic             lookup_req;
    logic [63:0]      lookup_addr;
    logic             lookup_gnt    = 1'b0;
    logic             lookup_valid  = 1'b0;
    logic             lookup_hit    = 1'b0;
    logic             lookup_dirty  = 1'b0;
    logic             lookup_shared = 1'b0;
    logic [LineW-1:0] lookup_data   = '0;
    logic             update_req;
    logic [1:0]       update_op;
    logic             update_gnt    = 1'b0;

    logic        ac_ready, cr_valid, cd_valid, cd_last;
    logic [4:0]  cr_resp;
    logic [63:0] cd_data;
    assign ac_ready = snoop_resp.ac_ready;
    assign cr_valid = snoop_resp.cr_valid;
    assign cr_resp  = snoop_resp.cr_resp;
    assign cd_valid = snoop_resp.cd_valid;
    assign cd_data  = snoop_resp.cd.data;
    assign cd_last  = snoop_resp.cd.last;

    ccu_snoop_responder #(
        .DcacheLineWidth(LineW),
        .AxiDataWidth   (DataW),
        .AddrWidth      (64)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .snoop_req_i    (snoop_req),
        .snoop_resp_o   (snoop_resp),
        .lookup_req_o   (lookup_req),
        .lookup_addr_o  (lookup_addr),
        .lookup_gnt_i   (lookup_gnt),
        .lookup_valid_i (lookup_valid),
        .lookup_hit_i   (lookup_hit),
        .lookup_dirty_i (lookup_dirty),
        .lookup_shared_i(lookup_shared),
        .lookup_data_i  (lookup_data),
        .update_req_o   (update_req),
        .update_op_o    (update_op),
        .update_gnt_i   (update_gnt)
    );

    typedef struct {
        logic             hit;
        logic             dirty;
        logic             shared;
        logic [LineW-1:0] data;
        logic [63:0]      addr;
    } lk_t;
    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } beat_t;

    lk_t        lk_q[$];
    logic [4:0] exp_cr_q[$];
    logic [1:0] exp_upd_q[$];
    beat_t      exp_cd_q[$];

    int checks   = 0;
    int errors   = 0;
    int txn_id   = 0;
    int cr_stall = 0;
    int cd_stall = 0;
    bit rnd_rdy  = 1'b0;
    bit rnd_gnt  = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_evt(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: got %s (t=%0t)", name, what, $time);
    endtask

    // Reference: {upd_op[1:0], cr_resp[4:0]} straight from the snoop decision table.
    function automatic logic [6:0] ref_decide(input logic [3:0] s, input logic hit,
                                              input logic dirty, input logic shared);
        logic       dt, pd, is_sh, known;
        logic [1:0] upd;
        dt = 1'b0; pd = 1'b0; is_sh = 1'b0; upd = 2'd0; known = 1'b1;
        if (s == 4'd0) begin
            dt = 1'b1; is_sh = 1'b1;
        end else if (s >= 4'd1 && s <= 4'd3) begin
            dt = 1'b1; pd = dirty; is_sh = 1'b1; upd = 2'd2;
        end else if (s == 4'd7) begin
            dt = 1'b1; pd = dirty; upd = 2'd3;
        end else if (s == 4'd9) begin
            dt = dirty; pd = dirty; upd = 2'd3;
        end else if (s == 4'd8) begin
            dt = dirty; pd = dirty; is_sh = 1'b1; upd = dirty ? 2'd1 : 2'd0;
        end else if (s == 4'd13) begin
            upd = 2'd3;
        end else begin
            known = 1'b0;
        end
        if (!hit || !known) return 7'd0;
        return {upd, ~shared, is_sh, pd, 1'b0, dt};
    endfunction

    task automatic send(input logic [3:0] s, input logic h, input logic d, input logic sh,
                        input logic [LineW-1:0] data, input logic [63:0] addr);
        logic [6:0] r;
        lk_t        e;
        beat_t      b;
        bit         done;
        r = ref_decide(s, h, d, sh);
        e.hit = h; e.dirty = d; e.shared = sh; e.data = data; e.addr = addr;
        lk_q.push_back(e);
        exp_cr_q.push_back(r[4:0]);
        if (r[6:5] != 2'd0) exp_upd_q.push_back(r[6:5]);
        if (r[0]) begin
            for (int i = 0; i < Words; i++) begin
                b.data = data[i*DataW +: DataW];
                b.last = (i == Words - 1);
                exp_cd_q.push_back(b);
            end
        end
        $display("txn %0d: snoop=%h hit=%b dirty=%b shared=%b addr=%h -> cr=%b upd=%0d",
                 txn_id, s, h, d, sh, addr, r[4:0], r[6:5]);
        txn_id++;
        @(negedge clk_i);
        ac_valid = 1'b1; ac_snoop = s; ac_addr = addr;
        done = 1'b0;
        for (int n = 0; n < 500 && !done; n++) begin
            if (ac_ready && rst_ni) begin
                done = 1'b1;
                @(posedge clk_i);
                #1;
                ac_valid = 1'b0;
            end else begin
                @(negedge clk_i);
            end
        end
        if (!done) begin
            fail_evt("ac_accept_timeout", "no ac_ready in 500 cycles");
            ac_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 3000 && !done; n++) begin
            @(negedge clk_i);
            if (lk_q.size() == 0 && exp_cr_q.size() == 0 && exp_upd_q.size() == 0 &&
                exp_cd_q.size() == 0 && !cr_valid && !cd_valid && ac_ready)
                done = 1'b1;
        end
        if (!done) fail_evt("idle_timeout", "responder still busy after 3000 cycles");
    endtask

    // Dcache lookup side: random grant, result returned 1..3 cycles after the grant.
    initial begin
        int lk_delay;
        lk_t e;
        lk_delay = 0;
        forever begin
            @(negedge clk_i);
            lookup_gnt   = 1'b0;
            lookup_valid = 1'b0;
            if (!rst_ni) begin
                lk_delay = 0;
            end else if (lk_delay > 0) begin
                lk_delay--;
                if (lk_delay == 0) begin
                    if (lk_q.size() == 0) begin
                        fail_evt("lookup_result", "lookup with no pending snoop");
                    end else begin
                        e = lk_q.pop_front();
                        lookup_valid  = 1'b1;
                        lookup_hit    = e.hit;
                        lookup_dirty  = e.dirty;
                        lookup_shared = e.shared;
                        lookup_data   = e.data;
                    end
                end
            end else if (lookup_req && (!rnd_gnt || $urandom_range(0, 2) != 0)) begin
                lookup_gnt = 1'b1;
                lk_delay   = 1 + int'($urandom_range(0, 2));
                if (lk_q.size() == 0) fail_evt("lookup_addr", "lookup_req with no pending snoop");
                else chk("lookup_addr", lookup_addr, lk_q[0].addr & ~64'hF);
            end
        end
    end

    // Dcache update side: random grant; the op is scored at the granted cycle.
    initial begin
        forever begin
            @(negedge clk_i);
            update_gnt = 1'b0;
            if (rst_ni && update_req && (!rnd_gnt || $urandom_range(0, 2) != 0)) begin
                update_gnt = 1'b1;
                if (exp_upd_q.size() == 0) fail_evt("update_op", "unexpected update_req");
                else chk("update_op", update_op, exp_upd_q.pop_front());
            end
        end
    end

    // CCU side: drives CR/CD ready, scores handshakes, checks ordering and stability.
    initial begin
        bit          cd_allowed, ac_exp, cr_pend, cd_pend;
        logic [4:0]  prev_cr;
        logic [64:0] prev_cd;
        logic [4:0]  ecr;
        beat_t       eb;
        cd_allowed = 0; ac_exp = 0; cr_pend = 0; cd_pend = 0; prev_cr = '0; prev_cd = '0;
        forever begin
            @(negedge clk_i);
            if (cr_stall > 0 && cr_valid) begin
                cr_ready = 1'b0; cr_stall--;
            end else begin
                cr_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (cd_stall > 0 && cd_valid) begin
                cd_ready = 1'b0; cd_stall--;
            end else begin
                cd_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (!rst_ni) begin
                cd_allowed = 0; ac_exp = 0; cr_pend = 0; cd_pend = 0;
            end else begin
                if (ac_exp) chk("ac_ready_after_done", ac_ready, 1'b1);
                ac_exp = 0;
                if (cr_pend) chk("cr_hold_stable", {cr_valid, cr_resp}, {1'b1, prev_cr});
                if (cd_pend) chk("cd_hold_stable", {cd_valid, cd_data, cd_last}, {1'b1, prev_cd});
                if ((cr_valid || cd_valid) && ac_ready) fail_evt("ac_overlap", "ac_ready while responding");
                if (cr_valid && cr_ready) begin
                    if (exp_cr_q.size() == 0) begin
                        fail_evt("cr_resp", "unexpected CR handshake");
                    end else begin
                        ecr = exp_cr_q.pop_front();
                        chk("cr_resp", cr_resp, ecr);
                        if (ecr[0]) cd_allowed = 1;
                        else ac_exp = 1;
                    end
                end
                if (cd_valid && cd_ready) begin
                    chk("cd_after_cr", cd_allowed, 1'b1);
                    if (exp_cd_q.size() == 0) begin
                        fail_evt("cd_beat", "extra CD beat");
                    end else begin
                        eb = exp_cd_q.pop_front();
                        chk("cd_beat", {cd_data, cd_last}, eb);
                        if (eb.last) begin
                            cd_allowed = 0; ac_exp = 1;
                        end
                    end
                end
                cr_pend = cr_valid && !cr_ready;
                prev_cr = cr_resp;
                cd_pend = cd_valid && !cd_ready;
                prev_cd = {cd_data, cd_last};
            end
        end
    end

    initial begin
        logic [LineW-1:0] line;
        logic [3:0]       codes [8];
        logic [3:0]       s;
        bit               seen;
        line  = {64'h2222, 64'h1111};
        codes = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd8, 4'd9, 4'd13};

        repeat (2) @(negedge clk_i);
        chk("reset_ac_ready", ac_ready, 1'b0);
        chk("reset_valids", {cr_valid, cd_valid, lookup_req, update_req}, 4'b0000);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("idle_ac_ready", ac_ready, 1'b1);

        send(4'd1, 1, 1, 0, line, 64'h0000_0000_0000_1238);  // ReadShared hit dirty unique
        wait_idle();
        send(4'd7, 1, 0, 1, line, 64'h0000_0000_0000_2040);  // ReadUnique hit clean shared
        wait_idle();
        send(4'd0, 0, 0, 0, line, 64'h0000_0000_0000_3000);  // ReadOnce miss
        wait_idle();
        send(4'd8, 1, 0, 0, line, 64'h0000_0000_0000_4010);  // CleanShared hit clean
        wait_idle();
        send(4'd8, 1, 1, 1, line, 64'h0000_0000_0000_5020);  // CleanShared hit dirty
        wait_idle();
        cd_stall = 5;
        send(4'd7, 1, 0, 0, line, 64'h0000_0000_0000_6000);  // CD stalled on beat 0
        wait_idle();

        // Reset while the line is being streamed out.
        cr_stall = 3;
        cd_stall = 50;
        send(4'd1, 1, 1, 1, line, 64'h0000_0000_0000_7000);
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk_i);
            if (cd_valid) seen = 1'b1;
        end
        if (!seen) fail_evt("reach_send_cd", "no cd_valid within 200 cycles");
        rst_ni = 1'b0;
        #1;
        chk("async_reset_outputs", {ac_ready, cr_valid, cd_valid, lookup_req, update_req}, 5'b00000);
        exp_cd_q.delete();
        cd_stall = 0;
        cr_stall = 0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        send(4'd13, 1, 1, 0, line, 64'h0000_0000_0000_8000);  // MakeInvalid after reset
        wait_idle();

        rnd_rdy = 1'b1;
        rnd_gnt = 1'b1;
        for (int i = 0; i < 200; i++) begin
            s = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : codes[$urandom_range(0, 7)];
            send(s, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom});
        end
        wait_idle();
        chk("queues_drained", lk_q.size() + exp_cr_q.size() + exp_upd_q.size() + exp_cd_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
